// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional early-out for |rs1| < |rs2| when DIV_EARLY_OUT_EN is defined.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MINV = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   rem, quo, dvs;
    logic              is_rem, q_neg, r_neg;

    logic              accept, sgn, s1, s2;
    logic              zero_div, ovf, early, special;
    logic [XLEN-1:0]   mag1, mag2, q_fix, r_fix;
    logic [XLEN:0]     rem_sh, diff;

    assign accept   = (state == IDLE) && div_start && div_op[2] && !flush;
    assign sgn      = !div_op[0];
    assign s1       = sgn & rs1_val[XLEN-1];
    assign s2       = sgn & rs2_val[XLEN-1];
    assign mag1     = s1 ? -rs1_val : rs1_val;
    assign mag2     = s2 ? -rs2_val : rs2_val;
    assign zero_div = (rs2_val == '0);
    assign ovf      = sgn && (rs1_val == MINV) && (rs2_val == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early    = !zero_div && !ovf && (mag1 < mag2);
`else
    assign early    = 1'b0;
`endif
    assign special  = zero_div | ovf | early;

    // 33-bit trial subtraction; the sign bit decides restore vs keep
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    assign q_fix = q_neg ? -quo : quo;
    assign r_fix = r_neg ? -rem : rem;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? FIX : CALC;
            CALC: begin
                if (flush)            state_nxt = IDLE;
                else if (cnt == LAST) state_nxt = FIX;
            end
            FIX:     state_nxt = flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            is_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_rem <= div_op[1];
                    rd_out <= rd_in;
                    cnt    <= '0;
                    dvs    <= mag2;
                    // Special cases preload final values with no sign fix-up
                    if (zero_div) begin
                        quo   <= '1;
                        rem   <= rs1_val;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                    end else if (ovf) begin
                        quo   <= MINV;
                        rem   <= '0;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                    end else if (early) begin
                        quo   <= '0;
                        rem   <= rs1_val;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                    end else begin
                        quo   <= mag1;
                        rem   <= '0;
                        q_neg <= s1 ^ s2;
                        r_neg <= s1;
                    end
                end
                CALC: if (!flush) begin
                    quo <= {quo[XLEN-2:0], !diff[XLEN]};
                    rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!flush) result <= is_rem ? r_fix : q_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .div_start(div_start), .div_op(div_op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'($signed(a) % $signed(b))
                         : 32'($signed(a) / $signed(b));
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int latency(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] ma, mb;
        if (b == 0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return 34;
`endif
        return 34;
    endfunction

    // Caller is mid-cycle in IDLE; this cycle becomes the accept cycle 0
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        int got = 0;
        int exp_lat;
        logic busy_ok = 1'b1;
        logic [31:0] res = '0;
        logic [4:0] rdo = '0;
        exp_lat = latency(op, a, b);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        div_start = 1'b1;
        div_op    = op;
        rs1_val   = a;
        rs2_val   = b;
        rd_in     = rd;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) div_start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                got = c;
                res = result;
                rdo = rd_out;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(got), 32'(exp_lat));
        chk({tag, "_res"}, res, model(op, a, b));
        chk({tag, "_rd"}, {27'b0, rdo}, {27'b0, rd});
        chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_post"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int seen;

        rst_n = 1'b0; div_start = 1'b0; div_op = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0; flush = 1'b0;
        #1;
        chk("reset_out", {busy, done, result[29:0]}, 32'd0);
        chk("reset_rd", {27'b0, rd_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("div_100_7", 3'b100, 32'd100, 32'd7, 5'd5);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd2);
        run_op("divu_z", 3'b101, 32'h1234_5678, 32'd0, 5'd3);
        run_op("remu_z", 3'b111, 32'h1234_5678, 32'd0, 5'd4);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        run_op("divu_3_10", 3'b101, 32'd3, 32'd10, 5'd8);
        run_op("remu_3_10", 3'b111, 32'd3, 32'd10, 5'd9);
        run_op("divu_max", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd31);
        run_op("div_min_1", 3'b100, 32'h8000_0000, 32'd1, 5'd10);

        // Invalid op is ignored
        div_start = 1'b1; div_op = 3'b010; rs1_val = 32'd5; rs2_val = 32'd1;
        @(posedge clk); #1;
        div_start = 1'b0;
        chk("invalid_op", {31'b0, busy}, 32'd0);

        // Flush in cycle 10, restart in cycle 11
        div_start = 1'b1; div_op = 3'b101;
        rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd12;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) div_start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {30'b0, busy, done}, 32'd0);
        run_op("after_flush", 3'b101, 32'd9, 32'd3, 5'd13);

        // Async reset mid-operation
        div_start = 1'b1; div_op = 3'b100;
        rs1_val = 32'd5000; rs2_val = 32'd7; rd_in = 5'd14;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) div_start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out", {busy, done, result[29:0]}, 32'd0);
        chk("rst_mid_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("rst_no_done", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'($urandom_range(0, 50)); b = $urandom | 32'h100; end
                4: b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
